// File: rtl/paralelo_serial_if.sv
// Bus for the 10-bit parallel-to-serial converter: word in, serial bit
// and frame/divided clocks out.
interface paralelo_serial_if;
  logic       enb;
  logic [9:0] entradas;
  logic       salida;
  logic       clk10;
  logic       clk20;
  logic       clk40;

  modport master (
    output enb, entradas,
    input  salida, clk10, clk20, clk40
  );

  modport slave (
    input  enb, entradas,
    output salida, clk10, clk20, clk40
  );
endinterface

// File: rtl/paralelo_serial.sv
// 10-bit parallel-to-serial converter, MSB first, with a frame clock (/10)
// and two further divided clocks (/20, /40) all aligned to the word load.
module paralelo_serial (
  input  logic              clk,
  input  logic              rst,
  paralelo_serial_if.slave  bus
);

  logic [3:0] r_cnt;
  logic [9:0] r_sh;
  logic       r_clk10;
  logic       r_clk20;
  logic       r_clk40;

  logic [3:0] w_cnt_next;
  logic [9:0] w_sh_next;
  logic       w_clk10_next;
  logic       w_clk20_next;
  logic       w_clk40_next;
  logic       w_load;

  assign w_load = (r_cnt == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd9;
      r_sh    <= '0;
      r_clk10 <= 1'b0;
      r_clk20 <= 1'b0;
      r_clk40 <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_sh    <= w_sh_next;
      r_clk10 <= w_clk10_next;
      r_clk20 <= w_clk20_next;
      r_clk40 <= w_clk40_next;
    end
  end

  // Everything holds unless enabled; a load edge needs enb as well.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_sh_next    = r_sh;
    w_clk10_next = r_clk10;
    w_clk20_next = r_clk20;
    w_clk40_next = r_clk40;
    if (bus.enb) begin
      if (w_load) begin
        w_cnt_next   = 4'd0;
        w_sh_next    = bus.entradas;
        w_clk20_next = ~r_clk20;
        w_clk40_next = r_clk20 ? ~r_clk40 : r_clk40;
      end else begin
        w_cnt_next   = r_cnt + 4'd1;
        w_sh_next    = {r_sh[8:0], 1'b0};
      end
      w_clk10_next = (w_cnt_next < 4'd5);
    end
  end

  always_comb begin
    bus.salida = r_sh[9];
    bus.clk10  = r_clk10;
    bus.clk20  = r_clk20;
    bus.clk40  = r_clk40;
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: directed scenarios plus randomized traffic,
// each checked against an edge-count/frame-number reference model.
module tb_paralelo_serial;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  paralelo_serial_if bus ();

  paralelo_serial u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_n counts enabled edges since reset. Edge 1 is the
  // first load, so bit position is (n-1)%10 and frame number (n-1)/10+1.
  int         m_n;
  logic [9:0] m_word;

  task automatic model_edge();
    if (rst) begin
      m_n = 0;
    end else if (bus.enb) begin
      m_n++;
      if ((m_n - 1) % 10 == 0) m_word = bus.entradas;
    end
  endtask

  function automatic logic [3:0] exp_vec();
    int pos;
    int f;
    if (m_n == 0) return 4'b0000;
    pos = (m_n - 1) % 10;
    f   = (m_n - 1) / 10 + 1;
    return {m_word[9 - pos], (pos < 5), f[0], f[1]};
  endfunction

  function automatic logic [3:0] dut_vec();
    return {bus.salida, bus.clk10, bus.clk20, bus.clk40};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] vals [5];
    vals[0] = 10'b1010010101;
    vals[1] = 10'b0000000001;
    vals[2] = 10'b1111111110;
    vals[3] = 10'b0111111111;
    vals[4] = 10'b1000000000;
    rst = 1'b1;
    bus.enb = 1'b1;
    m_n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.entradas = vals[i / 2];
      tick();
      total++;
      if (dut_vec() !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, dut_vec());
      end
    end
  endtask

  task automatic test_basic();
    logic [9:0] pat;
    pat = 10'b1100101100;
    bus.entradas = pat;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (bus.salida !== pat[9 - (i % 10)]) begin
        bad++;
        $display("FAIL basic_bit i=%0d got=%b want=%b", i, bus.salida, pat[9 - (i % 10)]);
      end
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL basic_model i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_word_change();
    logic [9:0] w1;
    logic [9:0] w2;
    logic       want;
    w1 = 10'b1111100000;
    w2 = 10'b0000011111;
    bus.entradas = w1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) bus.entradas = w2;
      tick();
      want = (i < 10) ? w1[9 - i] : w2[19 - i];
      total++;
      if (bus.salida !== want || dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL word_change i=%0d got=%b want_bit=%b want_vec=%b",
                 i, dut_vec(), want, exp_vec());
      end
    end
  endtask

  task automatic test_dividers();
    int   r10, r20, r40, hi10;
    logic p10, p20, p40;
    r10 = 0; r20 = 0; r40 = 0; hi10 = 0;
    p10 = bus.clk10; p20 = bus.clk20; p40 = bus.clk40;
    for (int i = 0; i < 80; i++) begin
      bus.entradas = 10'($urandom);
      tick();
      if (!p10 && bus.clk10) r10++;
      if (!p20 && bus.clk20) r20++;
      if (!p40 && bus.clk40) r40++;
      if (bus.clk10) hi10++;
      p10 = bus.clk10; p20 = bus.clk20; p40 = bus.clk40;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL div_model i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if (r10 !== 8 || hi10 !== 40) begin
      bad++;
      $display("FAIL div_clk10 rises=%0d high=%0d want rises=8 high=40", r10, hi10);
    end
    total++;
    if (r20 !== 4 || r40 !== 2) begin
      bad++;
      $display("FAIL div_20_40 r20=%0d r40=%0d want r20=4 r40=2", r20, r40);
    end
  endtask

  task automatic test_enable_stall();
    int   k;
    logic p10;
    bus.entradas = 10'b1010010101;
    for (int i = 0; i < 4; i++) tick();
    bus.enb = 1'b0;
    bus.entradas = 10'b0101101010;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec() || bus.salida !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    bus.enb = 1'b1;
    bus.entradas = 10'b1010010101;
    k = 0;
    p10 = bus.clk10;
    for (int i = 0; i < 30; i++) begin
      tick();
      k++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL stall_resume i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (!p10 && bus.clk10) break;
      p10 = bus.clk10;
    end
    total++;
    if (3 + 7 + k !== 17) begin
      bad++;
      $display("FAIL stall_len got=%0d want=17", 3 + 7 + k);
    end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    m_n = 0;
    #1;
    total++;
    if (dut_vec() !== 4'b0000) begin
      bad++;
      $display("FAIL midframe_rst got=%b want=0000", dut_vec());
    end
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.entradas = 10'($urandom);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL post_rst i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.entradas = 10'($urandom);
      bus.enb = ($urandom_range(0, 9) < 8);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) == 0) rst = 1'b1;
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.enb = 1'b1;
    bus.entradas = '0;
    m_n = 0;
    m_word = '0;
    #1;
    test_reset();
    test_basic();
    test_word_change();
    test_dividers();
    test_enable_stall();
    test_midframe_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
PARALELO_SERIAL -- requirements
Module: paralelo_serial

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-002 Port `clk`: input, 1 bit, sole clock; all state changes on its rising edge.
REQ-003 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `enb`: input, 1 bit, enable; 0 freezes all state.
REQ-005 Port `entradas`: input, 10 bits, parallel word to serialize.
REQ-006 Port `salida`: output, 1 bit, serial data, MSB first.
REQ-007 Port `clk10`: output, 1 bit, frame clock, period 10 clk cycles.
REQ-008 Port `clk20`: output, 1 bit, divided clock, period 20 clk cycles.
REQ-009 Port `clk40`: output, 1 bit, divided clock, period 40 clk cycles.
REQ-010 The block SHALL have no parameters; word width is fixed at 10.

Function
REQ-011 Frame counter `cnt`: 4 bits, range 0..9; on each enabled edge it SHALL go 9->0, otherwise increment by 1.
REQ-012 Shift register `sh`: 10 bits.
  - Enabled edge with cnt==9: sh <= entradas (load).
  - Any other enabled edge: sh <= {sh[8:0],1'b0}.
REQ-013 `salida` SHALL equal sh[9] directly from the flop, with no combinational path from `entradas`.
REQ-014 Serial latency: the word sampled at load edge k SHALL present entradas[9-i] on `salida` during the cycle after edge k+i, for i=0..9.
  - Frames are back-to-back; the next word's MSB directly follows the previous word's LSB.
REQ-015 `entradas` SHALL be sampled only at load edges; changes at other times have no effect on `salida` until the next load.
REQ-016 `clk10` SHALL be registered: 1 while cnt is 0..4, 0 while cnt is 5..9.
  - Its rising edge coincides with the first bit of each frame.
  - Duty cycle is 50%.
REQ-017 `clk20` SHALL toggle on every load edge; it is registered.
REQ-018 `clk40` SHALL toggle on every load edge where `clk20` is 1 before the edge; it is registered.
REQ-019 With enb=0:
  - cnt, sh, salida, clk10, clk20 and clk40 SHALL all hold.
  - On re-enable, operation resumes from the held count with no skipped or repeated bit.
REQ-020 A load and enb=0 on the same edge SHALL resolve as no load; the load occurs at the next enabled edge with cnt==9.
REQ-021 The RTL SHALL be synthesizable to the team standard-cell library.
  - The gate-level netlist SHALL match the RTL cycle-for-cycle on all outputs after reset.

Reset
REQ-022 While rst=1, the block SHALL hold these values, independent of clk and enb:
  - cnt=9
  - sh=0, salida=0
  - clk10=0, clk20=0, clk40=0
REQ-023 Reset assertion mid-frame SHALL abort the frame immediately; partial words are discarded.
REQ-024 The first enabled edge after rst falls SHALL be a load edge (cnt 9->0).
  - clk10 rises at that edge, clk20 goes to 1 and clk40 stays 0.

Verification
REQ-025 Reset hold: rst=1 for 10 cycles while entradas changes through 1010010101, 0000000001, 1111111110, 0111111111, 1000000000 -> salida=0, clk10=clk20=clk40=0 throughout.
REQ-026 Basic serialization: release rst with entradas=1100101100 held -> salida sequence 1,1,0,0,1,0,1,1,0,0 repeating every 10 cycles, starting the cycle after the first edge.
REQ-027 Word change: change entradas 1111100000 -> 0000011111 mid-frame -> current frame completes as 1111100000; next frame outputs 0000011111.
REQ-028 Clock dividers: free-run for 80 cycles.
  - clk10 has period 10 (5 high, 5 low).
  - clk20 has period 20, clk40 has period 40.
  - All rising edges are aligned to load edges.
REQ-029 Enable stall: drop enb for 7 cycles in the middle of frame 1010010101 -> all outputs frozen during the stall; the remaining bits are emitted afterwards in order; frame length is extended by exactly 7.
REQ-030 Mid-frame reset and equivalence: assert rst at bit 4 -> outputs return to reset values at once; run the same random stimulus on RTL and netlist -> identical salida, clk10, clk20 and clk40 on every cycle.
